// File: rtl/d_mem_arbiter_pkg.sv
// Shared definitions for the two-requester d_mem arbiter: FSM encoding,
// default memory depth, requester indices and the address range helper.
package d_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_e;

   localparam int unsigned NUM_WORDS_DEFAULT = 32'd256;

   localparam logic REQ_IDX0 = 1'b0;
   localparam logic REQ_IDX1 = 1'b1;

   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] num_words);
      return (addr < num_words);
   endfunction

endpackage

// File: rtl/d_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module rr_arb2
   import d_mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       winner
);

   // Winner selection; the no-request case is irrelevant to the caller.
   always_comb begin
      winner = REQ_IDX0;
      case (req)
         2'b01:   winner = REQ_IDX0;
         2'b10:   winner = REQ_IDX1;
         2'b11:   winner = ~last_grant;
         default: winner = last_grant;
      endcase
   end

endmodule

// File: rtl/d_mem_arbiter.sv
// Arbitrates two single-outstanding requesters onto one combinational-read d_mem
// port, one transaction per IDLE -> ACCESS -> DONE pass.
module d_mem_arbiter
   import d_mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_WORDS = NUM_WORDS_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        ack0,
   output logic        err0,
   output logic [31:0] rdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        ack1,
   output logic        err1,
   output logic [31:0] rdata1,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_read_data
);

   arb_state_e  state_r;
   logic        last_grant_r;
   logic        win_r;
   logic        range_err_r;

   logic        winner_s;
   logic        sel_we_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic        sel_in_range_s;

   rr_arb2 u_rr_arb2 (
      .req        ({req1, req0}),
      .last_grant (last_grant_r),
      .winner     (winner_s)
   );

   // Route the winning requester's command fields to the latch point.
   always_comb begin
      if (winner_s == REQ_IDX1) begin
         sel_we_s    = we1;
         sel_addr_s  = addr1;
         sel_wdata_s = wdata1;
      end else begin
         sel_we_s    = we0;
         sel_addr_s  = addr0;
         sel_wdata_s = wdata0;
      end
      sel_in_range_s = addr_in_range(sel_addr_s, 32'(NUM_WORDS));
   end

   // Transaction FSM; mem_* registers double as the latched command so the
   // memory sees them straight from flops during ACCESS.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         last_grant_r   <= REQ_IDX1;
         win_r          <= REQ_IDX0;
         range_err_r    <= 1'b0;
         mem_address    <= 32'd0;
         mem_write_data <= 32'd0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         ack0           <= 1'b0;
         ack1           <= 1'b0;
         err0           <= 1'b0;
         err1           <= 1'b0;
         rdata0         <= 32'd0;
         rdata1         <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req0 || req1) begin
                  win_r       <= winner_s;
                  range_err_r <= ~sel_in_range_s;
                  state_r     <= ST_ACCESS;
                  if (sel_in_range_s) begin
                     mem_address    <= sel_addr_s;
                     mem_write_data <= sel_we_s ? sel_wdata_s : 32'd0;
                     mem_write      <= sel_we_s;
                     mem_read       <= ~sel_we_s;
                  end else begin
                     mem_address    <= 32'd0;
                     mem_write_data <= 32'd0;
                     mem_write      <= 1'b0;
                     mem_read       <= 1'b0;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               // Read data is combinational from d_mem, so capture it on exit.
               if (mem_read) begin
                  if (win_r == REQ_IDX1) begin
                     rdata1 <= mem_read_data;
                  end else begin
                     rdata0 <= mem_read_data;
                  end
               end else begin
                  rdata0 <= rdata0;
                  rdata1 <= rdata1;
               end
               mem_address    <= 32'd0;
               mem_write_data <= 32'd0;
               mem_read       <= 1'b0;
               mem_write      <= 1'b0;
               ack0           <= (win_r == REQ_IDX0);
               ack1           <= (win_r == REQ_IDX1);
               err0           <= (win_r == REQ_IDX0) && range_err_r;
               err1           <= (win_r == REQ_IDX1) && range_err_r;
               state_r        <= ST_DONE;
            end
            ST_DONE: begin
               ack0         <= 1'b0;
               ack1         <= 1'b0;
               err0         <= 1'b0;
               err1         <= 1'b0;
               last_grant_r <= win_r;
               state_r      <= ST_IDLE;
            end
            default: begin
               mem_address    <= 32'd0;
               mem_write_data <= 32'd0;
               mem_read       <= 1'b0;
               mem_write      <= 1'b0;
               ack0           <= 1'b0;
               ack1           <= 1'b0;
               err0           <= 1'b0;
               err1           <= 1'b0;
               state_r        <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Scoreboard bench for d_mem_arbiter: directed scenarios plus random two-requester
// traffic against a transaction-level model of arbitration and memory contents.
module tb_d_mem_arbiter;

   localparam int NUM_WORDS = 256;
   localparam int AW        = 8;
   localparam int N_RAND    = 600;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        ack0, err0, ack1, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_read, mem_write;

   d_mem_arbiter #(.NUM_WORDS(NUM_WORDS)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .err0(err0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .err1(err1), .rdata1(rdata1),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // d_mem stand-in: combinational read, write on the rising edge.
   logic [31:0] mem [0:NUM_WORDS-1];
   assign mem_read_data = (mem_read && mem_address < 32'(NUM_WORDS)) ? mem[mem_address[AW-1:0]] : 32'd0;
   always @(posedge clk)
      if (mem_write && mem_address < 32'(NUM_WORDS)) mem[mem_address[AW-1:0]] <= mem_write_data;

   // Reference model state.
   typedef struct { int who; logic err; logic [31:0] rdata; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] ref_mem [0:NUM_WORDS-1];
   logic [31:0] exp_rdata [2];
   int          m_last;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rr_model(input logic [1:0] pend);
      if (pend == 2'b11) return 1 - m_last;
      else if (pend[0]) return 0;
      else return 1;
   endfunction

   task automatic model_grant(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      logic inr;
      inr = (a < 32'(NUM_WORDS));
      if (inr && w) ref_mem[int'(a)] = d;
      if (inr && !w) exp_rdata[i] = ref_mem[int'(a)];
      e.who = i; e.err = !inr; e.rdata = exp_rdata[i];
      exp_q.push_back(e);
      m_last = i;
   endtask

   task automatic set_req(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      if (i == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
   endtask

   task automatic set_req_only(input int i, input logic r);
      if (i == 0) req0 = r; else req1 = r;
   endtask

   task automatic do_reset();
      check32("q_empty_at_reset", 32'(exp_q.size()), 32'd0);
      reset = 1'b1;
      #1;
      check32("rst_ctl", {26'd0, mem_read, mem_write, ack0, ack1, err0, err1}, 32'd0);
      check32("rst_addr", mem_address | mem_write_data, 32'd0);
      check32("rst_rdata", rdata0 | rdata1, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      m_last = 1;
      exp_rdata[0] = 32'd0;
      exp_rdata[1] = 32'd0;
   endtask

   // One uncontended transaction; starts and ends at a falling edge.
   task automatic do_single(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input bit drop_early);
      logic inr;
      inr = (a < 32'(NUM_WORDS));
      @(negedge clk);
      set_req(i, 1'b1, w, a, d);
      model_grant(i, w, a, d);
      @(negedge clk);
      check32("acc_mem_write", 32'(mem_write), 32'(inr && w));
      check32("acc_mem_read", 32'(mem_read), 32'(inr && !w));
      if (inr) check32("acc_mem_address", mem_address, a);
      if (inr && w) check32("acc_mem_wdata", mem_write_data, d);
      if (drop_early) set_req_only(i, 1'b0);
      @(negedge clk);
      check32("ack_latency", 32'((i == 0) ? ack0 : ack1), 32'd1);
      set_req_only(i, 1'b0);
   endtask

   task automatic contend(input int n, input logic [31:0] a0, input logic [31:0] a1);
      int w;
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, a0, 32'd0);
      set_req(1, 1'b1, 1'b0, a1, 32'd0);
      for (int k = 0; k < n; k++) begin
         w = rr_model(2'b11);
         model_grant(w, 1'b0, (w == 0) ? a0 : a1, 32'd0);
         @(negedge clk);
         @(negedge clk);
         check32("contend_ack_winner", 32'((w == 0) ? ack0 : ack1), 32'd1);
         check32("contend_ack_loser", 32'((w == 0) ? ack1 : ack0), 32'd0);
         @(negedge clk);
      end
      set_req_only(0, 1'b0);
      set_req_only(1, 1'b0);
   endtask

   // Monitor: every ack pops one expectation; exclusivity checked every cycle.
   exp_t mon_e;
   always @(negedge clk) begin
      if (!reset) begin
         check32("mem_rw_exclusive", 32'(mem_read & mem_write), 32'd0);
         check32("ack_exclusive", 32'(ack0 & ack1), 32'd0);
         if (ack0 || ack1) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b required no ack (t=%0t)", ack0, ack1, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check32("ack_requester", ack1 ? 32'd1 : 32'd0, 32'(mon_e.who));
               check32("err_value", 32'((mon_e.who == 0) ? err0 : err1), 32'(mon_e.err));
               check32("rdata_value", (mon_e.who == 0) ? rdata0 : rdata1, mon_e.rdata);
            end
         end else begin
            check32("err_without_ack", {30'd0, err0, err1}, 32'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic        pend [2], granted [2], drop [2];
   int          g_edge [2];
   logic        f_we [2];
   logic [31:0] f_addr [2], f_wd [2];
   logic [31:0] mem0_before;

   initial begin
      for (int k = 0; k < NUM_WORDS; k++) begin
         mem[k]     = 32'h1000_0000 + 32'(k) * 32'd3;
         ref_mem[k] = 32'h1000_0000 + 32'(k) * 32'd3;
      end
      reset = 1'b1;
      set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      do_reset();

      // Write then read back through requester 0.
      do_single(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
      do_single(0, 1'b0, 32'd5, 32'd0, 1'b0);
      check32("rdata0_after_read", rdata0, 32'hDEAD_BEEF);

      // Out-of-range write must not touch memory.
      mem0_before = mem[0];
      do_single(1, 1'b1, 32'd256, 32'hCAFE_F00D, 1'b0);
      check32("oor_mem0_unchanged", mem[0], mem0_before);
      do_single(1, 1'b0, 32'd5, 32'd0, 1'b0);

      // Fresh reset, then sustained contention.
      @(negedge clk);
      do_reset();
      contend(6, 32'd10, 32'd20);

      // Reset in the middle of a write access.
      @(negedge clk);
      set_req(0, 1'b1, 1'b1, 32'd7, 32'h1234_5678);
      @(negedge clk);
      check32("midrst_mem_write_before", 32'(mem_write), 32'd1);
      do_reset();
      set_req_only(0, 1'b0);
      repeat (4) @(negedge clk);
      do_single(1, 1'b0, 32'd7, 32'd0, 1'b0);

      // Requester drops req right after being granted.
      do_single(0, 1'b0, 32'd3, 32'd0, 1'b1);
      @(negedge clk);

      // Random traffic; the model decides grants from the free time and pointer.
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0; granted[i] = 1'b0; drop[i] = 1'b0; g_edge[i] = 0;
         f_we[i] = 1'b0; f_addr[i] = 32'd0; f_wd[i] = 32'd0;
      end
      begin
         int free_at;
         int w;
         logic [1:0] act;
         free_at = 0;
         for (int t = 0; t < N_RAND + 30; t++) begin
            for (int i = 0; i < 2; i++)
               if (pend[i] && granted[i] && t >= g_edge[i] + 3) pend[i] = 1'b0;
            if (t < N_RAND) begin
               for (int i = 0; i < 2; i++) begin
                  if (!pend[i] && $urandom_range(2, 0) == 0) begin
                     pend[i]    = 1'b1;
                     granted[i] = 1'b0;
                     drop[i]    = ($urandom_range(3, 0) == 0);
                     f_we[i]    = 1'($urandom_range(1, 0));
                     case ($urandom_range(7, 0))
                        0:       f_addr[i] = 32'(NUM_WORDS) + 32'($urandom_range(40, 0));
                        1:       f_addr[i] = 32'hFFFF_FFFF;
                        2, 3:    f_addr[i] = 32'($urandom_range(NUM_WORDS - 1, 0));
                        default: f_addr[i] = 32'($urandom_range(15, 0));
                     endcase
                     f_wd[i] = $urandom;
                  end
               end
            end
            act = {pend[1] & ~granted[1], pend[0] & ~granted[0]};
            if (t >= free_at && act != 2'b00) begin
               w = rr_model(act);
               model_grant(w, f_we[w], f_addr[w], f_wd[w]);
               granted[w] = 1'b1;
               g_edge[w]  = t;
               free_at    = t + 3;
            end
            for (int i = 0; i < 2; i++)
               set_req(i, pend[i] && !(granted[i] && drop[i] && t > g_edge[i]), f_we[i], f_addr[i], f_wd[i]);
            @(negedge clk);
         end
      end
      set_req_only(0, 1'b0);
      set_req_only(1, 1'b0);
      repeat (4) @(negedge clk);
      check32("drain_requests", {30'd0, pend[1], pend[0]}, 32'd0);
      check32("drain_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
